// File: rtl/kontakt_anforderung.sv
// kontakt_anforderung
//   Conditions the raw vehicle-contact pins of the traffic-light controller into
//   clean, held requests for the phase FSM. Each channel is independent:
//   2-FF synchronizer -> debounce counter -> registered rising-edge detect ->
//   request latch with acknowledge and sticky overflow flag.
//
// Ports
//   CLK          in   1          system clock (clk_100mhz from the pll)
//   reset        in   1          asynchronous, active-low; 0 = in reset
//   kontakt      in   N_KONTAKT  raw asynchronous contact pins
//   anf_ack      in   N_KONTAKT  1-cycle pulse from the controller: request consumed
//   belegt       out  N_KONTAKT  debounced level, 1 = vehicle present
//   anforderung  out  N_KONTAKT  pending request, held until acknowledged
//   ueberlauf    out  N_KONTAKT  sticky: a new request arrived while one was pending
//
// Request/acknowledge handshake (per channel):
//   anforderung acts as "valid" and stays high until the controller returns a
//   one-cycle anf_ack. A debounced rise seen in the same cycle as anf_ack wins,
//   so the request stays set and ueberlauf clears. A rise while a request is
//   still pending and unacknowledged sets ueberlauf. anf_ack without a pending
//   request is ignored.

module kontakt_anforderung #(
  parameter int N_KONTAKT       = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int ACTIVE_HIGH     = 1
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic [N_KONTAKT-1:0] kontakt,
  input  logic [N_KONTAKT-1:0] anf_ack,
  output logic [N_KONTAKT-1:0] belegt,
  output logic [N_KONTAKT-1:0] anforderung,
  output logic [N_KONTAKT-1:0] ueberlauf
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Normalized level: 1 always means "vehicle present" from here on, so the
  // synchronizer reset value 0 is the inactive level for either pin polarity.
  logic [N_KONTAKT-1:0] lvl;
  logic [N_KONTAKT-1:0] s1;
  logic [N_KONTAKT-1:0] s2;
  logic [N_KONTAKT-1:0] belegt_d;
  logic [N_KONTAKT-1:0] rise;
  logic [CW-1:0]        cnt [N_KONTAKT];

  assign lvl  = (ACTIVE_HIGH != 0) ? kontakt : ~kontakt;
  assign rise = belegt & ~belegt_d;

  // Two-stage synchronizer for the asynchronous pins.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= lvl;
      s2 <= s1;
    end
  end

  // Debounce: belegt follows s2 only after s2 has differed from it for
  // DEBOUNCE_CYCLES consecutive cycles. Any return to agreement restarts the count.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      belegt <= '0;
      for (int i = 0; i < N_KONTAKT; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_KONTAKT; i++) begin
        if (s2[i] == belegt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          belegt[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Delayed copy of belegt for the rising-edge detect. Reset to 0 so a contact
  // already active at reset release is still seen as a rise.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      belegt_d <= '0;
    end else begin
      belegt_d <= belegt;
    end
  end

  // Request latch and sticky overflow flag.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      anforderung <= '0;
      ueberlauf   <= '0;
    end else begin
      for (int i = 0; i < N_KONTAKT; i++) begin
        if (rise[i]) begin
          anforderung[i] <= 1'b1;
          if (anf_ack[i]) begin
            ueberlauf[i] <= 1'b0;
          end else if (anforderung[i]) begin
            ueberlauf[i] <= 1'b1;
          end
        end else if (anf_ack[i] && anforderung[i]) begin
          anforderung[i] <= 1'b0;
          ueberlauf[i]   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_kontakt_anforderung.sv
// tb_kontakt_anforderung
//   Directed bench for kontakt_anforderung with DEBOUNCE_CYCLES=4, N_KONTAKT=2.
//   Two instances share clock and reset: dut_h (pins active high) and dut_l
//   (pins active low). Inputs change 1 ns after a rising edge; outputs are
//   sampled at the same point, so after setting a pin the first edge that
//   samples it is reached after one tick and belegt follows after six ticks,
//   anforderung after seven.
//   Observed vectors are packed as {belegt[1:0], anforderung[1:0], ueberlauf[1:0]}.

`timescale 1ns/1ps

module tb_kontakt_anforderung;

  localparam int N  = 2;
  localparam int DC = 4;

  // Clock/reset block
  logic CLK;
  logic reset;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  logic [N-1:0] kontakt_h, anf_ack_h, belegt_h, anforderung_h, ueberlauf_h;
  logic [N-1:0] kontakt_l, anf_ack_l, belegt_l, anforderung_l, ueberlauf_l;

  kontakt_anforderung #(
    .N_KONTAKT(N), .DEBOUNCE_CYCLES(DC), .ACTIVE_HIGH(1)
  ) dut_h (
    .CLK(CLK), .reset(reset), .kontakt(kontakt_h), .anf_ack(anf_ack_h),
    .belegt(belegt_h), .anforderung(anforderung_h), .ueberlauf(ueberlauf_h)
  );

  kontakt_anforderung #(
    .N_KONTAKT(N), .DEBOUNCE_CYCLES(DC), .ACTIVE_HIGH(0)
  ) dut_l (
    .CLK(CLK), .reset(reset), .kontakt(kontakt_l), .anf_ack(anf_ack_l),
    .belegt(belegt_l), .anforderung(anforderung_l), .ueberlauf(ueberlauf_l)
  );

  int checks   = 0;
  int failures = 0;

  wire [5:0] obs_h = {belegt_h, anforderung_h, ueberlauf_h};
  wire [5:0] obs_l = {belegt_l, anforderung_l, ueberlauf_l};

  // Driver tasks
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic pulse_ack_h(input logic [N-1:0] a);
    anf_ack_h = a;
    tick(1);
    anf_ack_h = '0;
  endtask

  task automatic test_reset();
    logic [5:0] exp;
    reset     = 1'b0;
    kontakt_h = '0;
    kontakt_l = '1;
    anf_ack_h = '0;
    anf_ack_l = '0;
    tick(2);
    exp = 6'b000000;
    checks++;
    if (obs_h !== exp) begin failures++; $display("FAIL reset_h got=%b exp=%b", obs_h, exp); end
    checks++;
    if (obs_l !== exp) begin failures++; $display("FAIL reset_l got=%b exp=%b", obs_l, exp); end
    reset = 1'b1;
    tick(3);
    checks++;
    if (obs_h !== exp) begin failures++; $display("FAIL idle_h got=%b exp=%b", obs_h, exp); end
    checks++;
    if (obs_l !== exp) begin failures++; $display("FAIL idle_l got=%b exp=%b", obs_l, exp); end
  endtask

  // Hold kontakt[0]: belegt after 6 ticks, request after 7, channel 1 quiet.
  task automatic test_debounce();
    logic [5:0] exp;
    kontakt_h = 2'b01;
    tick(5);
    exp = 6'b000000;
    checks++;
    if (obs_h !== exp) begin failures++; $display("FAIL deb_early got=%b exp=%b", obs_h, exp); end
    tick(1);
    exp = 6'b010000;
    checks++;
    if (obs_h !== exp) begin failures++; $display("FAIL deb_belegt got=%b exp=%b", obs_h, exp); end
    tick(1);
    exp = 6'b010100;
    checks++;
    if (obs_h !== exp) begin failures++; $display("FAIL deb_request got=%b exp=%b", obs_h, exp); end
    tick(3);
    checks++;
    if (obs_h !== exp) begin failures++; $display("FAIL deb_held got=%b exp=%b", obs_h, exp); end
    exp = 6'b000000;
    checks++;
    if (obs_l !== exp) begin failures++; $display("FAIL deb_low_idle got=%b exp=%b", obs_l, exp); end
  endtask

  // Ack clears the pending request; a second ack changes nothing.
  task automatic test_ack();
    logic [5:0] exp;
    pulse_ack_h(2'b01);
    exp = 6'b010000;
    checks++;
    if (obs_h !== exp) begin failures++; $display("FAIL ack_clear got=%b exp=%b", obs_h, exp); end
    pulse_ack_h(2'b01);
    tick(1);
    checks++;
    if (obs_h !== exp) begin failures++; $display("FAIL ack_ignored got=%b exp=%b", obs_h, exp); end
  endtask

  // Release (no request on fall), then a 3-cycle glitch that must be filtered,
  // then a clean press whose timing shows the counter restarted from 0.
  task automatic test_glitch();
    logic [5:0] exp;
    kontakt_h = 2'b00;
    tick(5);
    exp = 6'b010000;
    checks++;
    if (obs_h !== exp) begin failures++; $display("FAIL fall_early got=%b exp=%b", obs_h, exp); end
    tick(1);
    exp = 6'b000000;
    checks++;
    if (obs_h !== exp) begin failures++; $display("FAIL fall_no_req got=%b exp=%b", obs_h, exp); end
    kontakt_h = 2'b01;
    tick(3);
    kontakt_h = 2'b00;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checks++;
      if (obs_h !== exp) begin failures++; $display("FAIL glitch_%0d got=%b exp=%b", i, obs_h, exp); end
    end
    kontakt_h = 2'b01;
    tick(5);
    checks++;
    if (obs_h !== exp) begin failures++; $display("FAIL repress_early got=%b exp=%b", obs_h, exp); end
    tick(1);
    exp = 6'b010000;
    checks++;
    if (obs_h !== exp) begin failures++; $display("FAIL repress_belegt got=%b exp=%b", obs_h, exp); end
    tick(1);
    exp = 6'b010100;
    checks++;
    if (obs_h !== exp) begin failures++; $display("FAIL repress_req got=%b exp=%b", obs_h, exp); end
  endtask

  // Second rise with request still pending sets ueberlauf; ack clears both.
  task automatic test_overflow();
    logic [5:0] exp;
    kontakt_h = 2'b00;
    tick(6);
    exp = 6'b000100;
    checks++;
    if (obs_h !== exp) begin failures++; $display("FAIL ovf_release got=%b exp=%b", obs_h, exp); end
    kontakt_h = 2'b01;
    tick(6);
    exp = 6'b010100;
    checks++;
    if (obs_h !== exp) begin failures++; $display("FAIL ovf_pre got=%b exp=%b", obs_h, exp); end
    tick(1);
    exp = 6'b010101;
    checks++;
    if (obs_h !== exp) begin failures++; $display("FAIL ovf_set got=%b exp=%b", obs_h, exp); end
    pulse_ack_h(2'b01);
    exp = 6'b010000;
    checks++;
    if (obs_h !== exp) begin failures++; $display("FAIL ovf_ack got=%b exp=%b", obs_h, exp); end
  endtask

  // Rise in the same cycle as ack: the new request wins.
  task automatic test_back_to_back();
    logic [5:0] exp;
    kontakt_h = 2'b00;
    tick(6);
    exp = 6'b000000;
    checks++;
    if (obs_h !== exp) begin failures++; $display("FAIL b2b_release got=%b exp=%b", obs_h, exp); end
    kontakt_h = 2'b01;
    tick(6);
    exp = 6'b010000;
    checks++;
    if (obs_h !== exp) begin failures++; $display("FAIL b2b_belegt got=%b exp=%b", obs_h, exp); end
    pulse_ack_h(2'b01);
    exp = 6'b010100;
    checks++;
    if (obs_h !== exp) begin failures++; $display("FAIL b2b_rise_wins got=%b exp=%b", obs_h, exp); end
    pulse_ack_h(2'b01);
    exp = 6'b010000;
    checks++;
    if (obs_h !== exp) begin failures++; $display("FAIL b2b_ack got=%b exp=%b", obs_h, exp); end
  endtask

  // Reset mid-debounce and with a pending request; contacts held active through
  // reset release give a request 7 ticks later on both polarities.
  task automatic test_reset_mid();
    logic [5:0] exp;
    kontakt_h = 2'b10;
    tick(6);
    exp = 6'b100000;
    checks++;
    if (obs_h !== exp) begin failures++; $display("FAIL rm_swap got=%b exp=%b", obs_h, exp); end
    tick(1);
    exp = 6'b101000;
    checks++;
    if (obs_h !== exp) begin failures++; $display("FAIL rm_pending got=%b exp=%b", obs_h, exp); end
    kontakt_h = 2'b11;
    kontakt_l = 2'b00;
    tick(3);
    #3;
    reset = 1'b0;
    #1;
    exp = 6'b000000;
    checks++;
    if (obs_h !== exp) begin failures++; $display("FAIL rm_async_h got=%b exp=%b", obs_h, exp); end
    checks++;
    if (obs_l !== exp) begin failures++; $display("FAIL rm_async_l got=%b exp=%b", obs_l, exp); end
    tick(2);
    checks++;
    if (obs_h !== exp) begin failures++; $display("FAIL rm_hold_h got=%b exp=%b", obs_h, exp); end
    reset = 1'b1;
    tick(6);
    exp = 6'b110000;
    checks++;
    if (obs_h !== exp) begin failures++; $display("FAIL rm_belegt_h got=%b exp=%b", obs_h, exp); end
    checks++;
    if (obs_l !== exp) begin failures++; $display("FAIL rm_belegt_l got=%b exp=%b", obs_l, exp); end
    tick(1);
    exp = 6'b111100;
    checks++;
    if (obs_h !== exp) begin failures++; $display("FAIL rm_req_h got=%b exp=%b", obs_h, exp); end
    checks++;
    if (obs_l !== exp) begin failures++; $display("FAIL rm_req_l got=%b exp=%b", obs_l, exp); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_ack();
    test_glitch();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
